aer_event_decoder: RTL
======================

// Module: aer_event_decoder
// PURPOSE
//  Receiving end of the 4-phase AER link driven by the pixel spike encoder. Synchronises AER_REQ,
//  captures AER_ADDR = {timestamp, pixel address}, answers with AER_ACK, and buffers decoded events
//  in a FWFT FIFO toward the neuron core. Backpressure: no ACK while the FIFO is full.
// PARAMETERS
//  TS_W          4     timestamp field width, AER_ADDR[TS_W+ADDR_W-1:ADDR_W]
//  ADDR_W        12    pixel/neuron address field width, AER_ADDR[ADDR_W-1:0]
//  FIFO_DEPTH    16    event FIFO entries (power of 2, >=2)
//  INPUT_NEURON  2048  number of valid input addresses (used by AER_ADDR_CHECK_EN)
// PORTS
//  CLK         in   1            system clock
//  RST         in   1            async active-high reset
//  AER_REQ     in   1            request from encoder (asynchronous domain, level)
//  AER_ADDR    in   TS_W+ADDR_W  event word, stable while AER_REQ high
//  AER_ACK     out  1            acknowledge to encoder
//  evt_valid   out  1            FIFO head valid (= !empty)
//  evt_ready   in   1            consumer pops head when evt_valid & evt_ready
//  evt_ts      out  TS_W         head timestamp
//  evt_addr    out  ADDR_W       head address
//  evt_ts_new  out  1            head is first event of a new timestamp
//  fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy
//  err_count   out  16           out-of-range events discarded (0 unless AER_ADDR_CHECK_EN)
// BEHAVIOUR
//  Reset: AER_ACK=0, FIFO empty (evt_valid=0, fifo_count=0), err_count=0, sync flops 0, state IDLE,
//   last_ts_valid=0. Outputs are registered; the handshake is fully async w.r.t. encoder timing.
//  Sync: req_s1<=AER_REQ, req_syn<=req_s1 (2 FF). AER_ADDR is sampled only when req_syn=1.
//  FSM (2 states):
//   IDLE: req_syn=1 & fifo_count<FIFO_DEPTH -> push {ts,addr,ts_new}, AER_ACK<=1, -> ACK.
//         req_syn=1 & FIFO full -> stay IDLE, ACK stays 0 (encoder stalls); retry every cycle.
//   ACK:  hold AER_ACK=1 until req_syn=0; that cycle AER_ACK<=0, -> IDLE. Exactly one push per
//         REQ pulse regardless of how long REQ stays high.
//  Latency: REQ rises before edge k -> req_syn=1 after edge k+1 -> push & ACK=1 after edge k+2;
//   evt_valid=1 after edge k+2 if FIFO was empty (FWFT, write visible next cycle).
//  ts_new: set on a push when last_ts_valid=0 or ts != last_ts; last_ts updated on every push.
//   Wrap 15->0 is a change; repeated identical ts across gaps is not.
//  FIFO: push and pop in the same cycle are both honoured (count unchanged); full check uses
//   current count, so a pop in the same cycle does not free space for a push (push waits 1 cycle).
//   Pop on empty ignored; pointers wrap modulo FIFO_DEPTH.
//  Reset mid-handshake: ACK forced 0, FIFO flushed; if REQ still high after RST release it is
//   accepted again as a fresh event (the encoder re-sees an ACK edge).
// CONFIGURATION
//  AER_ADDR_CHECK_EN defined: event with addr >= INPUT_NEURON is still ACKed (link never hangs) but
//   not pushed; err_count increments (saturates at 16'hFFFF); last_ts not updated.
//  Not defined: every event pushed unchecked; err_count tied to 0.
// TESTING
//  1 REQ=1 ADDR=16'h3005, evt_ready=1 -> ACK=1 3 cycles later; evt_ts=3, evt_addr=12'h005,
//    evt_ts_new=1; drop REQ -> ACK=0 3 cycles later.
//  2 REQ held high 50 cycles -> single push, fifo_count=1, ACK high until REQ falls.
//  3 evt_ready=0, 17 back-to-back events -> 16 ACKed, fifo_count=16, 17th ACK withheld;
//    one pop -> 17th ACKed one cycle after space appears.
//  4 events ts 15,15,0 -> evt_ts_new = 1,0,1.
//  5 AER_ADDR_CHECK_EN, ADDR=16'h1900 (2304) -> ACKed, FIFO unchanged, err_count=1.
//  6 RST pulse while ACK=1 with 5 queued -> ACK=0, evt_valid=0, fifo_count=0 same cycle.

Source files
------------

// File: rtl/aer_event_decoder.sv
// AER link receiver: 2-FF request synchroniser, 4-phase ACK handshake and FWFT event FIFO.
// Optional macro AER_ADDR_CHECK_EN: discard (but still ACK) events with addr >= INPUT_NEURON.
module aer_event_decoder #(
    parameter int TS_W         = 4,
    parameter int ADDR_W       = 12,
    parameter int FIFO_DEPTH   = 16,
    parameter int INPUT_NEURON = 2048
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          AER_REQ,
    input  logic [TS_W+ADDR_W-1:0]        AER_ADDR,
    output logic                          AER_ACK,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [TS_W-1:0]               evt_ts,
    output logic [ADDR_W-1:0]             evt_addr,
    output logic                          evt_ts_new,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   err_count
);

    // state  | meaning
    // IDLE   | waiting for synchronised REQ; push + raise ACK when FIFO has room
    // ACK    | ACK held high until synchronised REQ falls

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TS_W + ADDR_W + 1;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(INPUT_NEURON);
`ifdef AER_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_ACK} state_t;

    state_t             state_q, state_d;
    logic               req_s1_q, req_syn_q;
    logic               ack_q, ack_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        err_q, err_d;
    logic [TS_W-1:0]    last_ts_q, last_ts_d;
    logic               last_ts_valid_q, last_ts_valid_d;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

    logic               push, pop, ts_new, addr_bad;
    logic [TS_W-1:0]    in_ts;
    logic [ADDR_W-1:0]  in_addr;
    logic [ENT_W-1:0]   entry, head;

    always_comb begin
        state_d         = state_q;
        ack_d           = ack_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        err_d           = err_q;
        last_ts_d       = last_ts_q;
        last_ts_valid_d = last_ts_valid_q;
        push            = 1'b0;
        pop             = (cnt_q != '0) && evt_ready;
        in_ts           = AER_ADDR[TS_W+ADDR_W-1:ADDR_W];
        in_addr         = AER_ADDR[ADDR_W-1:0];
        ts_new          = !last_ts_valid_q || (in_ts != last_ts_q);
        addr_bad        = CHECK_EN && ({1'b0, in_addr} >= ADDR_LIMIT);
        entry           = {in_ts, in_addr, ts_new};

        case (state_q)
            S_IDLE: begin
                if (req_syn_q) begin
                    // Bad addresses are acknowledged regardless of room so the link never hangs.
                    if (addr_bad) begin
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    end else if (cnt_q < CNT_W'(FIFO_DEPTH)) begin
                        push            = 1'b1;
                        ack_d           = 1'b1;
                        state_d         = S_ACK;
                        last_ts_d       = in_ts;
                        last_ts_valid_d = 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (!req_syn_q) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= S_IDLE;
            req_s1_q        <= 1'b0;
            req_syn_q       <= 1'b0;
            ack_q           <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            err_q           <= '0;
            last_ts_q       <= '0;
            last_ts_valid_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            req_s1_q        <= AER_REQ;
            req_syn_q       <= req_s1_q;
            ack_q           <= ack_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            last_ts_q       <= last_ts_d;
            last_ts_valid_q <= last_ts_valid_d;
            if (push) mem_q[wr_ptr_q] <= entry;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign AER_ACK    = ack_q;
    assign evt_valid  = (cnt_q != '0);
    assign evt_ts     = head[ENT_W-1 -: TS_W];
    assign evt_addr   = head[ADDR_W:1];
    assign evt_ts_new = head[0];
    assign fifo_count = cnt_q;
    assign err_count  = err_q;

endmodule
